// File: rtl/bram_mailbox_reader.sv
// PL-side reader for the PS->PL mailbox in the shared BRAM: on a doorbell edge it validates the
// header at word 0 and streams words 1..len out over a registered valid/ready interface.
module bram_mailbox_reader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] MAGIC      = 16'hC0DE,
  parameter int unsigned MAX_LEN    = 2047
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  doorbell_in,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  irq_done,
  output logic                  busy,
  output logic                  err_hdr,
  output logic                  ovr
);

  typedef enum logic [2:0] {StIdle, StHdr, StChk, StStream, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic                    db_meta_q, db_sync_q, db_prev_q, start;
  logic [ADDR_WIDTH-1:0]   len_q, len_d, rd_cnt_q, rd_cnt_d, ld_cnt_q, ld_cnt_d, addr_q, addr_d;
  logic                    dv_q, rd_issue;
  logic [DATA_WIDTH-1:0]   fifo_q [2];
  logic [DATA_WIDTH-1:0]   fifo_d [2];
  logic [1:0]              fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic                    mvalid_q, mvalid_d, mlast_q, mlast_d;
  logic                    err_q, err_d, ovr_q, ovr_d;
  logic [ADDR_WIDTH-1:0]   hdr_len;
  logic                    hdr_bad, out_free, take_fifo, take_bus;
  logic                    unused_hdr;

  assign start      = db_sync_q & ~db_prev_q;
  assign hdr_len    = bram_dout[ADDR_WIDTH-1:0];
  assign hdr_bad    = (bram_dout[31:16] != MAGIC) || (hdr_len == '0) || (32'(hdr_len) > MAX_LEN);
  assign unused_hdr = ^bram_dout[15:ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_meta_q <= 1'b0;
      db_sync_q <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      db_meta_q <= doorbell_in;
      db_sync_q <= db_meta_q;
      db_prev_q <= db_sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    addr_d    = addr_q;
    fifo_d    = fifo_q;
    fcnt_d    = fcnt_q;
    mdata_d   = mdata_q;
    mvalid_d  = mvalid_q;
    mlast_d   = mlast_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    rd_issue  = 1'b0;
    bram_en   = 1'b0;
    out_free  = !mvalid_q || m_ready;
    take_fifo = 1'b0;
    take_bus  = 1'b0;

    if (start && state_q != StIdle) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        bram_en = 1'b1;
        addr_d  = '0;
        state_d = StChk;
      end
      StChk: begin
        // Header word is on bram_dout for exactly this cycle.
        if (hdr_bad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          len_d    = hdr_len;
          rd_cnt_d = '0;
          ld_cnt_d = '0;
          state_d  = StStream;
        end
      end
      StStream: begin
        // Reads in flight plus buffered words never exceed the two skid slots.
        rd_issue = (rd_cnt_q < len_q) && ((fcnt_q + {1'b0, dv_q}) < 2'd2);
        if (rd_issue) begin
          bram_en  = 1'b1;
          addr_d   = rd_cnt_q + AddrOne;
          rd_cnt_d = rd_cnt_q + AddrOne;
        end
        take_fifo = out_free && (fcnt_q != 2'd0);
        take_bus  = out_free && (fcnt_q == 2'd0) && dv_q;
        if (out_free) begin
          mvalid_d = take_fifo || take_bus;
          mlast_d  = 1'b0;
          if (take_fifo) begin
            mdata_d = fifo_q[0];
          end else if (take_bus) begin
            mdata_d = bram_dout;
          end
          if (take_fifo || take_bus) begin
            mlast_d  = (ld_cnt_q + AddrOne) == len_q;
            ld_cnt_d = ld_cnt_q + AddrOne;
          end
        end
        if (take_fifo) begin
          fifo_d[0] = fifo_q[1];
          fcnt_d    = fcnt_q - 2'd1;
        end
        if (dv_q && !take_bus) begin
          fifo_d[fcnt_d[0]] = bram_dout;
          fcnt_d            = fcnt_d + 2'd1;
        end
        if (mvalid_q && m_ready && mlast_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      ld_cnt_q  <= '0;
      addr_q    <= '0;
      dv_q      <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fcnt_q    <= '0;
      mdata_q   <= '0;
      mvalid_q  <= 1'b0;
      mlast_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      addr_q    <= addr_d;
      dv_q      <= rd_issue;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      fcnt_q    <= fcnt_d;
      mdata_q   <= mdata_d;
      mvalid_q  <= mvalid_d;
      mlast_q   <= mlast_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bram_addr = addr_d;
  assign m_data    = mdata_q;
  assign m_valid   = mvalid_q;
  assign m_last    = mlast_q;
  assign irq_done  = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign err_hdr   = err_q;
  assign ovr       = ovr_q;

endmodule
